// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared constants, state encoding and Game-of-Life rule for the row update stage
package life_pkg;

    localparam int X_SIZE  = 1280;
    localparam int Y_SIZE  = 720;
    localparam int X_WIDTH = $clog2(X_SIZE);
    localparam int Y_WIDTH = $clog2(Y_SIZE);
    localparam int CHUNK   = 64;
    localparam int NCHUNK  = X_SIZE / CHUNK;
    localparam int C_WIDTH = $clog2(NCHUNK);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_SKIP    = 2'd3;

    function automatic logic life_rule(input logic [3:0] count, input logic alive);
        return (count == 4'd3) | (alive & (count == 4'd2));
    endfunction

endpackage

// File: rtl/life_chunk_next.sv
// rtl/life_chunk_next.sv - combinational next-state for one CHUNK-wide window
// Slice bit k+1 is the cell for output bit k; bits 0 and CHUNK+1 are the neighbouring-chunk halo.
module life_chunk_next
    import life_pkg::*;
(
    input  logic [CHUNK+1:0] top_i,
    input  logic [CHUNK+1:0] mid_i,
    input  logic [CHUNK+1:0] bot_i,
    output logic [CHUNK-1:0] next_o
);

    for (genvar k = 0; k < CHUNK; k++) begin : g_cell
        logic [3:0] count;
        assign count = {3'b0, top_i[k]} + {3'b0, top_i[k+1]} + {3'b0, top_i[k+2]}
                     + {3'b0, mid_i[k]}                      + {3'b0, mid_i[k+2]}
                     + {3'b0, bot_i[k]} + {3'b0, bot_i[k+1]} + {3'b0, bot_i[k+2]};
        assign next_o[k] = life_rule(count, mid_i[k+1]);
    end

endmodule

// File: rtl/life_row_update.sv
// rtl/life_row_update.sv - computes one Game-of-Life generation for a row, CHUNK cells per cycle
// The latched rows are zero-padded by one bit each side so grid edges read as dead.
module life_row_update
    import life_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_set,
    input  logic               calc_flag_in,
    input  logic [Y_WIDTH-1:0] calc_row_in,
    input  logic [X_SIZE-1:0]  top,
    input  logic [X_SIZE-1:0]  middle,
    input  logic [X_SIZE-1:0]  bottom,
    output logic               busy,
    output logic               wr_en,
    output logic [Y_WIDTH-1:0] wr_addr,
    output logic [X_SIZE-1:0]  wr_data,
    output logic               done
);

    if (X_SIZE % CHUNK != 0) begin : g_bad_chunk
        $fatal(1, "X_SIZE must be a multiple of CHUNK");
    end

    logic [1:0]         state_q, state_d;
    logic [C_WIDTH-1:0] chunk_q, chunk_d;
    logic [X_SIZE-1:0]  top_q, top_d, mid_q, mid_d, bot_q, bot_d;
    logic [Y_WIDTH-1:0] row_q, row_d;
    logic [X_SIZE-1:0]  result_q, result_d;
    logic               wr_en_q, wr_en_d, done_q, done_d;
    logic [Y_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [X_SIZE-1:0]  wr_data_q, wr_data_d;

    logic [X_SIZE+1:0]  pad_top, pad_mid, pad_bot;
    logic [X_WIDTH-1:0] base;
    logic [CHUNK+1:0]   win_top, win_mid, win_bot;
    logic [CHUNK-1:0]   chunk_next;

    assign pad_top = {1'b0, top_q, 1'b0};
    assign pad_mid = {1'b0, mid_q, 1'b0};
    assign pad_bot = {1'b0, bot_q, 1'b0};
    assign base    = X_WIDTH'(chunk_q) * X_WIDTH'(CHUNK);
    assign win_top = pad_top[base +: CHUNK+2];
    assign win_mid = pad_mid[base +: CHUNK+2];
    assign win_bot = pad_bot[base +: CHUNK+2];

    life_chunk_next u_chunk (
        .top_i  (win_top),
        .mid_i  (win_mid),
        .bot_i  (win_bot),
        .next_o (chunk_next)
    );

    always_comb begin
        state_d   = state_q;
        chunk_d   = chunk_q;
        top_d     = top_q;
        mid_d     = mid_q;
        bot_d     = bot_q;
        row_d     = row_q;
        result_d  = result_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_set && calc_flag_in) begin
                    top_d    = top;
                    mid_d    = middle;
                    bot_d    = bottom;
                    row_d    = calc_row_in;
                    result_d = '0;
                    chunk_d  = '0;
                    state_d  = ST_COMPUTE;
                end else if (valid_set) begin
                    state_d = ST_SKIP;
                end
            end
            ST_COMPUTE: begin
                result_d[base +: CHUNK] = chunk_next;
                if (chunk_q == C_WIDTH'(NCHUNK-1)) begin
                    chunk_d   = '0;
                    state_d   = ST_WRITE;
                    wr_addr_d = row_q;
                    wr_data_d = result_d;
                end else begin
                    chunk_d = chunk_q + C_WIDTH'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        wr_en_d = (state_d == ST_WRITE);
        done_d  = (state_d == ST_WRITE) || (state_d == ST_SKIP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            chunk_q   <= '0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            row_q     <= '0;
            result_q  <= '0;
            wr_en_q   <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            chunk_q   <= chunk_d;
            top_q     <= top_d;
            mid_q     <= mid_d;
            bot_q     <= bot_d;
            row_q     <= row_d;
            result_q  <= result_d;
            wr_en_q   <= wr_en_d;
            done_q    <= done_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign wr_en   = wr_en_q;
    assign done    = done_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule
